// File: rtl/sc_dmem_pkg.sv
// Shared types and constants for the data-memory/IO bus: FSM state, IO word offsets
// and the active-low seven-segment table.
package sc_dmem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [4:0] IO_SW    = 5'd0;
    localparam logic [4:0] IO_LED   = 5'd1;
    localparam logic [4:0] IO_HEX0  = 5'd2;
    localparam logic [4:0] IO_TIMER = 5'd8;

    // Segments ordered gfedcba, active-low; digit F in the top slice, digit 0 in the bottom.
    localparam logic [16*7-1:0] SEG7_LUT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] value);
        return SEG7_LUT[7*value +: 7];
    endfunction

endpackage

// File: rtl/sc_hex7seg_dec.sv
// Combinational 4-bit hex value to active-low seven-segment pattern.
module sc_hex7seg_dec
    import sc_dmem_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_lookup(value);
    end

endmodule

// File: rtl/sc_datamem_bus.sv
// Data-memory/IO subsystem: word RAM plus memory-mapped switches, LEDs and hex digits.
// Optional free-running cycle counter at IO word 8 when SC_DMEM_TIMER_EN is defined.
module sc_datamem_bus
    import sc_dmem_pkg::*;
#(
    parameter int RAM_AW     = 5,
    parameter int IO_SEL_BIT = 7,
    parameter int NUM_SW     = 10,
    parameter int NUM_LED    = 10,
    parameter int NUM_HEX    = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    output logic                 ready,
    output logic [31:0]          dataout,
    input  logic [NUM_SW-1:0]    io_in_sw,
    output logic [NUM_LED-1:0]   io_out_led,
    output logic [7*NUM_HEX-1:0] io_out_hex,
    output logic                 dbg_state
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    // Handshake: the master raises req with we/be/addr/datain stable and holds them until
    // ready. The request is taken on the first rising edge seen in IDLE; ready then pulses
    // for exactly one cycle and dataout is meaningful only while ready is high.

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                io_sel;
    logic                io_wr;
    logic [RAM_AW-1:0]   ram_word;
    logic [4:0]          io_word;
    logic [31:0]         io_rdata;
    logic [31:0]         ram [RAM_DEPTH];
    logic [NUM_SW-1:0]   sw_meta;
    logic [NUM_SW-1:0]   sw_sync;
    logic [NUM_LED-1:0]  led_q;
    logic [4*NUM_HEX-1:0] hex_q;
    logic                unused_addr_bits;

    assign accept   = (state == ST_IDLE) && req && !reset;
    assign io_sel   = addr[IO_SEL_BIT];
    assign ram_word = addr[RAM_AW+1:2];
    assign io_word  = addr[6:2];
    assign io_wr    = accept && we && io_sel && be[0];

    assign unused_addr_bits = ^{addr[31:IO_SEL_BIT+1], addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == ST_RESP);
        dbg_state = (state == ST_RESP);
    end

    // Two-flop synchroniser for the raw board switches.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= io_in_sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
            hex_q <= '0;
        end else begin
            if (io_wr && io_word == IO_LED) begin
                led_q <= datain[NUM_LED-1:0];
            end
            for (int i = 0; i < NUM_HEX; i++) begin
                if (io_wr && io_word == IO_HEX0 + 5'(i)) begin
                    hex_q[4*i +: 4] <= datain[3:0];
                end
            end
        end
    end

`ifdef SC_DMEM_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else if (io_wr && io_word == IO_TIMER) begin
            timer_q <= datain;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`endif

    always_comb begin
        io_rdata = '0;
        if (io_word == IO_SW) begin
            io_rdata[NUM_SW-1:0] = sw_sync;
        end
        if (io_word == IO_LED) begin
            io_rdata[NUM_LED-1:0] = led_q;
        end
        for (int i = 0; i < NUM_HEX; i++) begin
            if (io_word == IO_HEX0 + 5'(i)) begin
                io_rdata[3:0] = hex_q[4*i +: 4];
            end
        end
`ifdef SC_DMEM_TIMER_EN
        if (io_word == IO_TIMER) begin
            io_rdata = timer_q;
        end
`endif
    end

    // RAM contents survive reset; only accepted writes touch the array.
    always_ff @(posedge clock) begin
        if (accept && we && !io_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram[ram_word][8*b +: 8] <= datain[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dataout <= '0;
        end else if (accept && !we) begin
            dataout <= io_sel ? io_rdata : ram[ram_word];
        end
    end

    assign io_out_led = led_q;

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        sc_hex7seg_dec u_dec (
            .value (hex_q[4*g +: 4]),
            .seg   (io_out_hex[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_sc_datamem_bus.sv
// Directed bench for sc_datamem_bus: driver tasks push expected read data into exp_q,
// a negedge monitor pops and compares whenever ready is high.
module tb_sc_datamem_bus;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        ready;
    logic [31:0] dataout;
    logic [9:0]  io_in_sw;
    logic [9:0]  io_out_led;
    logic [41:0] io_out_hex;
    logic        dbg_state;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        in_resp = 1'b0;

    sc_datamem_bus dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .datain     (datain),
        .ready      (ready),
        .dataout    (dataout),
        .io_in_sw   (io_in_sw),
        .io_out_led (io_out_led),
        .io_out_hex (io_out_hex),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [41:0] hex_vec(input logic [23:0] digits);
        logic [41:0] v;
        for (int i = 0; i < 6; i++) v[7*i +: 7] = seg_of(digits[4*i +: 4]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
        in_resp = 1'b0;
    endtask

    // Issues one access and waits for its ready; a call made in the response cycle of the
    // previous access must wait one extra edge before being accepted.
    task automatic do_access(input logic w, input logic [3:0] b, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input string name);
        int lat;
        int want;
        want = in_resp ? 2 : 1;
        exp_q.push_back({~w, exp});
        we = w; be = b; addr = a; datain = d; req = 1'b1;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (ready !== 1'b1 && lat < 8);
        req = 1'b0;
        check({name, "_latency"}, lat, want);
        in_resp = 1'b1;
    endtask

    always @(negedge clock) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: dataout %0h with no access outstanding", dataout);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[32]) begin
                    checks++;
                    if (dataout !== mon_e[31:0]) begin
                        errors++;
                        $display("FAIL rd_data: got %0h expected %0h", dataout, mon_e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0;
        addr = 32'h0; datain = 32'h0; io_in_sw = 10'h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", ready, 0);
        check("rst_dataout", dataout, 0);
        check("rst_led", io_out_led, 0);
        check("rst_hex", io_out_hex, hex_vec(24'h0));
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        in_resp = 1'b0;

        do_access(1'b0, 4'h0, 32'h84, 32'h0, 32'h0, "rd_led_reset");

        do_access(1'b1, 4'hF,    32'h04,  32'h0,        32'h0, "wr_clr");
        do_access(1'b1, 4'b0101, 32'h04,  32'h12345678, 32'h0, "wr_be0101");
        do_access(1'b0, 4'h0,    32'h04,  32'h0,        32'h00340078, "rd_be0101");
        do_access(1'b1, 4'b1010, 32'h104, 32'hAABBCCDD, 32'h0, "wr_alias");
        do_access(1'b0, 4'h0,    32'h04,  32'h0,        32'hAA34CC78, "rd_alias");
        do_access(1'b1, 4'b0000, 32'h04,  32'hFFFFFFFF, 32'h0, "wr_be0");
        do_access(1'b0, 4'h0,    32'hF04, 32'h0,        32'hAA34CC78, "rd_be0");
        do_access(1'b1, 4'hF,    32'h7C,  32'h11112222, 32'h0, "wr_top");
        do_access(1'b0, 4'h0,    32'h7C,  32'h0,        32'h11112222, "rd_top");
        do_access(1'b0, 4'h0,    32'h04,  32'h0,        32'hAA34CC78, "rd_neighbor");

        io_in_sw = 10'h2A5;
        idle(3);
        do_access(1'b0, 4'h0, 32'h80, 32'h0,        32'h2A5, "rd_sw");
        do_access(1'b1, 4'hF, 32'h80, 32'hFFFFFFFF, 32'h0,   "wr_sw_ro");
        do_access(1'b0, 4'h0, 32'h80, 32'h0,        32'h2A5, "rd_sw_ro");

        do_access(1'b1, 4'b0001, 32'h84, 32'hFFFFF3C5, 32'h0, "wr_led");
        check("led_after_wr", io_out_led, 10'h3C5);
        do_access(1'b1, 4'b1110, 32'h84, 32'h0, 32'h0, "wr_led_nobe0");
        check("led_nobe0", io_out_led, 10'h3C5);
        do_access(1'b0, 4'h0, 32'h84, 32'h0, 32'h3C5, "rd_led");
        do_access(1'b0, 4'h0, 32'hBC, 32'h0, 32'h0,   "rd_unmapped");

        do_access(1'b1, 4'b0001, 32'h88, 32'h3,        32'h0, "wr_hex0");
        do_access(1'b1, 4'b0001, 32'h8C, 32'hFFFFFFFF, 32'h0, "wr_hex1");
        do_access(1'b1, 4'b0001, 32'h90, 32'hA,        32'h0, "wr_hex2");
        check("hex_digit0", io_out_hex[6:0], 7'b0110000);
        check("hex_digit1", io_out_hex[13:7], 7'b0001110);
        check("hex_all", io_out_hex, hex_vec(24'h000AF3));
        do_access(1'b0, 4'h0, 32'h8C, 32'h0, 32'hF, "rd_hex1");

        // req held for six cycles, then reset lands in the third response cycle.
        idle(1);
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 32'hAA34CC78});
        we = 1'b0; be = 4'h0; addr = 32'h04; datain = 32'h0; req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            check("ready_pattern", ready, k % 2);
        end
        reset = 1'b1;
        req = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_ready", ready, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_led", io_out_led, 0);
        check("rst_mid_hex", io_out_hex, hex_vec(24'h0));
        reset = 1'b0;
        in_resp = 1'b0;
        do_access(1'b0, 4'h0, 32'h04, 32'h0, 32'hAA34CC78, "rd_ram_kept");

`ifdef SC_DMEM_TIMER_EN
        do_access(1'b1, 4'b0001, 32'hA0, 32'hFFFFFFFE, 32'h0,        "wr_timer");
        do_access(1'b0, 4'h0,    32'hA0, 32'h0,        32'hFFFFFFFF, "rd_timer0");
        do_access(1'b0, 4'h0,    32'hA0, 32'h0,        32'h1,        "rd_timer1");
`else
        do_access(1'b1, 4'b0001, 32'hA0, 32'hFFFFFFFE, 32'h0, "wr_timer");
        do_access(1'b0, 4'h0,    32'hA0, 32'h0,        32'h0, "rd_timer0");
        do_access(1'b0, 4'h0,    32'hA0, 32'h0,        32'h0, "rd_timer1");
`endif

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
